// File: rtl/alu_step_sequencer.sv
// Sequences one jALU operation: latches operands, presents them, captures result and flags.
// Optional feature macro ALU_SEQ_CARRY_IN_EN feeds the stored carry back as jALU carry-in.
module alu_step_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             wclk,
    input  logic             wrst_n,
    input  logic             wstart,
    input  logic [2:0]       bop,
    input  logic [WIDTH-1:0] bra,
    input  logic [WIDTH-1:0] brb,
    input  logic             wclf,
    output logic [WIDTH-1:0] bas,
    output logic [WIDTH-1:0] bbs,
    output logic             wci,
    output logic [2:0]       bops,
    input  logic [WIDTH-1:0] bcs,
    input  logic             wco,
    input  logic             weqo,
    input  logic             walo,
    input  logic             wz,
    output logic             wready,
    output logic             wdone,
    output logic             wwr,
    output logic [WIDTH-1:0] bresult,
    output logic [3:0]       bflags
);

    // state | meaning
    // IDLE  | ready for a request; operands held from the last accept
    // S4    | operands settling at the jALU
    // S5    | capture jALU result and flags at the end of the cycle
    // S6    | done / write-enable strobe
    typedef enum logic [1:0] {IDLE, S4, S5, S6} state_t;

    localparam logic [2:0] OP_CMP = 3'd7;
    localparam logic [2:0] OP_XOR = 3'd6;

    state_t     state;
    logic [2:0] op_q;
    logic       carry_sel;

`ifdef ALU_SEQ_CARRY_IN_EN
    assign carry_sel = (bop <= 3'd2) ? bflags[3] : 1'b0;
`else
    assign carry_sel = 1'b0;
`endif

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state   <= IDLE;
            op_q    <= 3'd0;
            bas     <= '0;
            bbs     <= '0;
            bops    <= 3'd0;
            wci     <= 1'b0;
            wready  <= 1'b1;
            wdone   <= 1'b0;
            wwr     <= 1'b0;
            bresult <= '0;
            bflags  <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (wstart) begin
                        bas    <= bra;
                        bbs    <= brb;
                        op_q   <= bop;
                        bops   <= (bop == OP_CMP) ? OP_XOR : bop;
                        wci    <= carry_sel;
                        wready <= 1'b0;
                        state  <= S4;
                    end
                end
                S4: state <= S5;
                S5: begin
                    if (op_q != OP_CMP)
                        bresult <= bcs;
                    wdone <= 1'b1;
                    wwr   <= (op_q != OP_CMP);
                    state <= S6;
                end
                S6: begin
                    wdone  <= 1'b0;
                    wwr    <= 1'b0;
                    wready <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // flag capture in S5 takes priority over a clear request
            if (state == S5)
                bflags <= {wco, walo, weqo, wz};
            else if (wclf)
                bflags <= 4'd0;
        end
    end

endmodule
